knight_cmd_assembler: RTL and testbench

- Sits between the Knight's UART byte receiver/transmitter and the command processor, upstream of cmd_proc inside KnightsTour.
- Assembles two received bytes (high byte first) into a 16-bit command, e.g. 16'h6033 for a tour from (3,3), and presents it with a level ready flag.
- Serialises the 8-bit response (e.g. 8'hA5 positive ack) back out through the UART transmitter.
- Discards a stale half-command after an inter-byte timeout.

---
 rtl/knight_cmd_assembler.sv | 199 +++++++++++++++++++
 tb/tb_knight_cmd_assembler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_cmd_assembler.sv
// knight_cmd_assembler
//   Glue between the Knight's UART and cmd_proc. Two received bytes (high
//   byte first) are packed into a 16-bit command and held with a level
//   ready flag until the consumer acknowledges it. In parallel, an 8-bit
//   response byte is handed to the UART transmitter and its completion is
//   reported back.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   rx_rdy        UART RX has a byte (level, held until clr_rx_rdy)
//   rx_data       received byte
//   clr_rx_rdy    one-cycle pulse: byte consumed
//   cmd           assembled command {high, low}
//   cmd_rdy       level: cmd valid until clr_cmd_rdy
//   clr_cmd_rdy   consumer acknowledges cmd
//   resp          response byte to transmit
//   send_resp     pulse: transmit resp
//   tx_busy       UART TX busy
//   tx_data       byte presented to UART TX
//   trmt          one-cycle pulse: start UART TX
//   resp_sent     one-cycle pulse: response fully shifted out
//   frame_err     one-cycle pulse: partial command dropped on timeout
module knight_cmd_assembler #(
    parameter int BYTE_TMO = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        trmt,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam int TW = (BYTE_TMO > 1) ? $clog2(BYTE_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TMO - 1);

    typedef enum logic [1:0] {IDLE_HI, WAIT_LO, HOLD} cmd_state_t;
    typedef enum logic [1:0] {RIDLE, RWAIT, RSENT} resp_state_t;

    cmd_state_t    cmd_state, cmd_state_nxt;
    resp_state_t   resp_state, resp_state_nxt;

    logic [TW-1:0] timer, timer_nxt;
    logic [15:0]   cmd_nxt;
    logic          cmd_rdy_nxt, clr_rx_rdy_nxt, frame_err_nxt;

    logic [7:0]    tx_data_nxt;
    logic          trmt_nxt, resp_sent_nxt;
    logic          seen_busy, seen_busy_nxt;
    logic          post_trmt, post_trmt_nxt;

    logic          rx_take, tmo, sent_done;

    // rx_rdy is still high in the cycle our clear pulse is out, so a byte
    // only counts when we are not already clearing one.
    assign rx_take = rx_rdy && !clr_rx_rdy;
    assign tmo     = (timer == TMO_LAST);

    // A response is finished when busy has been seen and then drops, or
    // when busy never showed up in the two cycles following trmt.
    assign sent_done = seen_busy ? !tx_busy : (!tx_busy && post_trmt);

    // All state and every output live in this single register process so
    // that reset clears everything together and no output is combinational.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_state  <= IDLE_HI;
            timer      <= '0;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
            frame_err  <= 1'b0;
            resp_state <= RIDLE;
            tx_data    <= 8'h00;
            trmt       <= 1'b0;
            resp_sent  <= 1'b0;
            seen_busy  <= 1'b0;
            post_trmt  <= 1'b0;
        end else begin
            cmd_state  <= cmd_state_nxt;
            timer      <= timer_nxt;
            cmd        <= cmd_nxt;
            cmd_rdy    <= cmd_rdy_nxt;
            clr_rx_rdy <= clr_rx_rdy_nxt;
            frame_err  <= frame_err_nxt;
            resp_state <= resp_state_nxt;
            tx_data    <= tx_data_nxt;
            trmt       <= trmt_nxt;
            resp_sent  <= resp_sent_nxt;
            seen_busy  <= seen_busy_nxt;
            post_trmt  <= post_trmt_nxt;
        end
    end

    // Command FSM transitions. A low byte arriving on the expiry cycle is
    // checked first so it wins over the timeout.
    always_comb begin
        cmd_state_nxt = cmd_state;
        case (cmd_state)
            IDLE_HI: if (rx_take) cmd_state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (rx_take)  cmd_state_nxt = HOLD;
                else if (tmo) cmd_state_nxt = IDLE_HI;
            end
            HOLD:    if (clr_cmd_rdy) cmd_state_nxt = IDLE_HI;
            default: cmd_state_nxt = IDLE_HI;
        endcase
    end

    // Command FSM register updates. In HOLD the UART byte is deliberately
    // left unacknowledged so it stays buffered until cmd is consumed.
    always_comb begin
        cmd_nxt        = cmd;
        cmd_rdy_nxt    = cmd_rdy;
        timer_nxt      = timer;
        clr_rx_rdy_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (cmd_state)
            IDLE_HI: begin
                if (rx_take) begin
                    cmd_nxt[15:8]  = rx_data;
                    clr_rx_rdy_nxt = 1'b1;
                    timer_nxt      = '0;
                end
            end
            WAIT_LO: begin
                if (rx_take) begin
                    cmd_nxt[7:0]   = rx_data;
                    clr_rx_rdy_nxt = 1'b1;
                    cmd_rdy_nxt    = 1'b1;
                end else if (tmo) begin
                    frame_err_nxt  = 1'b1;
                end else begin
                    timer_nxt      = timer + 1'b1;
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) cmd_rdy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Response FSM transitions.
    always_comb begin
        resp_state_nxt = resp_state;
        case (resp_state)
            RIDLE: if (send_resp) resp_state_nxt = tx_busy ? RWAIT : RSENT;
            RWAIT: if (!tx_busy)  resp_state_nxt = RSENT;
            RSENT: if (sent_done) resp_state_nxt = RIDLE;
            default: resp_state_nxt = RIDLE;
        endcase
    end

    // Response FSM register updates. tx_data is only loaded from RIDLE, so
    // a send_resp that arrives mid-transfer cannot corrupt the byte in flight.
    always_comb begin
        tx_data_nxt   = tx_data;
        trmt_nxt      = 1'b0;
        resp_sent_nxt = 1'b0;
        seen_busy_nxt = seen_busy;
        post_trmt_nxt = post_trmt;
        case (resp_state)
            RIDLE: begin
                if (send_resp) begin
                    tx_data_nxt = resp;
                    if (!tx_busy) begin
                        trmt_nxt      = 1'b1;
                        seen_busy_nxt = 1'b0;
                        post_trmt_nxt = 1'b0;
                    end
                end
            end
            RWAIT: begin
                if (!tx_busy) begin
                    trmt_nxt      = 1'b1;
                    seen_busy_nxt = 1'b0;
                    post_trmt_nxt = 1'b0;
                end
            end
            RSENT: begin
                if (sent_done)    resp_sent_nxt = 1'b1;
                else if (tx_busy) seen_busy_nxt = 1'b1;
                else              post_trmt_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_knight_cmd_assembler.sv
// tb_knight_cmd_assembler
//   Directed bench for knight_cmd_assembler with a shortened byte timeout.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   sampled at the same point, so every observed value is the result of
//   the edge just passed.
module tb_knight_cmd_assembler;

    localparam int BYTE_TMO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        resp_sent;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    int fe_count   = 0;
    int clr_count  = 0;
    int trmt_count = 0;
    int rs_count   = 0;

    knight_cmd_assembler #(.BYTE_TMO(BYTE_TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, used to prove that a pulse happened
    // exactly once (or not at all) over a stretch of cycles.
    always @(negedge clk) begin
        if (frame_err === 1'b1)  fe_count++;
        if (clr_rx_rdy === 1'b1) clr_count++;
        if (trmt === 1'b1)       trmt_count++;
        if (resp_sent === 1'b1)  rs_count++;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One UART byte: rx_rdy rises, the DUT must pulse clr_rx_rdy one cycle
    // later, and the UART drops rx_rdy on the edge that sees the clear.
    task automatic applyStimulus(input logic [7:0] b, input logic [15:0] exp_cmd,
                                 input logic exp_rdy, input string tag);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        checkOutput({tag, "_clr"},  {15'd0, clr_rx_rdy}, 16'd1);
        checkOutput({tag, "_cmd"},  cmd, exp_cmd);
        checkOutput({tag, "_rdy"},  {15'd0, cmd_rdy}, {15'd0, exp_rdy});
        checkOutput({tag, "_ferr"}, {15'd0, frame_err}, 16'd0);
        tick();
        rx_rdy = 1'b0;
        checkOutput({tag, "_clr_once"}, {15'd0, clr_rx_rdy}, 16'd0);
    endtask

    task automatic clearCmd(input string tag);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        checkOutput({tag, "_rdy_clr"}, {15'd0, cmd_rdy}, 16'd0);
    endtask

    initial begin
        logic early;
        int   base_a, base_b;

        // ---------------- reset ----------------
        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_cmd",       cmd, 16'h0000);
        checkOutput("rst_cmd_rdy",   {15'd0, cmd_rdy}, 16'd0);
        checkOutput("rst_clr_rx",    {15'd0, clr_rx_rdy}, 16'd0);
        checkOutput("rst_frame_err", {15'd0, frame_err}, 16'd0);
        checkOutput("rst_trmt",      {15'd0, trmt}, 16'd0);
        checkOutput("rst_resp_sent", {15'd0, resp_sent}, 16'd0);
        checkOutput("rst_tx_data",   {8'd0, tx_data}, 16'h0000);
        rst = 1'b0;
        tick();

        // ---------------- basic two-byte command ----------------
        $display("[TB] command 6033");
        base_a = clr_count;
        applyStimulus(8'h60, 16'h6000, 1'b0, "t1_hi");
        idle(20);
        applyStimulus(8'h33, 16'h6033, 1'b1, "t1_lo");
        checkOutput("t1_clr_pulses", 16'(clr_count - base_a), 16'd2);
        idle(10);
        checkOutput("t1_hold_cmd", cmd, 16'h6033);
        checkOutput("t1_hold_rdy", {15'd0, cmd_rdy}, 16'd1);
        clearCmd("t1");
        checkOutput("t1_cmd_kept", cmd, 16'h6033);

        // ---------------- inter-byte timeout ----------------
        $display("[TB] timeout");
        base_a = fe_count;
        applyStimulus(8'h20, 16'h2033, 1'b0, "t2_hi");
        early = 1'b0;
        for (int i = 2; i < BYTE_TMO; i++) begin
            tick();
            if (frame_err !== 1'b0 || cmd_rdy !== 1'b0) early = 1'b1;
        end
        checkOutput("t2_no_early", {15'd0, early}, 16'd0);
        tick();
        checkOutput("t2_ferr",      {15'd0, frame_err}, 16'd1);
        checkOutput("t2_ferr_rdy",  {15'd0, cmd_rdy}, 16'd0);
        tick();
        checkOutput("t2_ferr_pulse", {15'd0, frame_err}, 16'd0);
        checkOutput("t2_ferr_count", 16'(fe_count - base_a), 16'd1);
        applyStimulus(8'h40, 16'h4033, 1'b0, "t2b_hi");
        applyStimulus(8'h01, 16'h4001, 1'b1, "t2b_lo");
        clearCmd("t2b");

        // ---------------- byte arriving while cmd held ----------------
        $display("[TB] byte during hold");
        applyStimulus(8'h60, 16'h6001, 1'b0, "t3_hi");
        applyStimulus(8'h33, 16'h6033, 1'b1, "t3_lo");
        base_a  = clr_count;
        rx_data = 8'h2F;
        rx_rdy  = 1'b1;
        idle(8);
        checkOutput("t3_no_ack",   16'(clr_count - base_a), 16'd0);
        checkOutput("t3_cmd_held", cmd, 16'h6033);
        checkOutput("t3_rdy_held", {15'd0, cmd_rdy}, 16'd1);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        checkOutput("t3_clr_wins_rdy", {15'd0, cmd_rdy}, 16'd0);
        checkOutput("t3_clr_wins_ack", {15'd0, clr_rx_rdy}, 16'd0);
        tick();
        checkOutput("t3_late_ack", {15'd0, clr_rx_rdy}, 16'd1);
        checkOutput("t3_late_cmd", cmd, 16'h2F33);
        tick();
        rx_rdy = 1'b0;
        checkOutput("t3_late_once", {15'd0, clr_rx_rdy}, 16'd0);
        applyStimulus(8'h00, 16'h2F00, 1'b1, "t3_lo2");
        clearCmd("t3");

        // ---------------- response while UART busy ----------------
        $display("[TB] response with busy tx");
        base_a    = trmt_count;
        base_b    = rs_count;
        tx_busy   = 1'b1;
        resp      = 8'hA5;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        checkOutput("t4_tx_data",  {8'd0, tx_data}, 16'h00A5);
        checkOutput("t4_no_trmt",  {15'd0, trmt}, 16'd0);
        idle(5);
        resp      = 8'h5A;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        checkOutput("t4_ignore_2nd", {8'd0, tx_data}, 16'h00A5);
        idle(43);
        checkOutput("t4_wait_no_trmt", 16'(trmt_count - base_a), 16'd0);
        tx_busy = 1'b0;
        tick();
        checkOutput("t4_trmt",      {15'd0, trmt}, 16'd1);
        checkOutput("t4_trmt_data", {8'd0, tx_data}, 16'h00A5);
        tx_busy = 1'b1;
        tick();
        checkOutput("t4_trmt_pulse", {15'd0, trmt}, 16'd0);
        idle(9);
        checkOutput("t4_not_sent_yet", 16'(rs_count - base_b), 16'd0);
        tx_busy = 1'b0;
        tick();
        checkOutput("t4_resp_sent", {15'd0, resp_sent}, 16'd1);
        tick();
        checkOutput("t4_sent_pulse", {15'd0, resp_sent}, 16'd0);
        idle(5);
        checkOutput("t4_trmt_total", 16'(trmt_count - base_a), 16'd1);
        checkOutput("t4_sent_total", 16'(rs_count - base_b), 16'd1);

        // ---------------- response, busy never seen ----------------
        $display("[TB] response with idle tx");
        resp      = 8'h3C;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        checkOutput("t4b_trmt",    {15'd0, trmt}, 16'd1);
        checkOutput("t4b_tx_data", {8'd0, tx_data}, 16'h003C);
        tick();
        checkOutput("t4b_not_yet", {15'd0, resp_sent}, 16'd0);
        tick();
        checkOutput("t4b_sent",    {15'd0, resp_sent}, 16'd1);
        tick();
        checkOutput("t4b_sent_pulse", {15'd0, resp_sent}, 16'd0);

        // ---------------- reset in WAIT_LO ----------------
        $display("[TB] reset mid-command");
        applyStimulus(8'h60, 16'h6000, 1'b0, "t5_hi");
        idle(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_rst_cmd", cmd, 16'h0000);
        checkOutput("t5_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        checkOutput("t5_rst_clr", {15'd0, clr_rx_rdy}, 16'd0);
        base_a = fe_count;
        applyStimulus(8'h12, 16'h1200, 1'b0, "t5b_hi");
        idle(50);
        applyStimulus(8'h34, 16'h1234, 1'b1, "t5b_lo");
        checkOutput("t5_no_ferr", 16'(fe_count - base_a), 16'd0);
        clearCmd("t5");

        // ---------------- low byte on the expiry cycle ----------------
        $display("[TB] low byte at expiry");
        base_a = fe_count;
        applyStimulus(8'hAB, 16'hAB34, 1'b0, "t6_hi");
        idle(BYTE_TMO - 2);
        applyStimulus(8'hCD, 16'hABCD, 1'b1, "t6_lo");
        checkOutput("t6_ferr_low", {15'd0, frame_err}, 16'd0);
        checkOutput("t6_no_ferr",  16'(fe_count - base_a), 16'd0);
        clearCmd("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
